hilo_seq: RTL and testbench
===========================

Name: hilo_seq

Overview:
- Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the P7 pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations decoded in E, runs mult/div for a fixed latency and commits results to HI/LO.
- Drives `busy` and a D-stage stall request.
- Honours the exception/flush cancel from the CP0 path so a squashed E-stage op never starts or writes.

Parameters:
MULT_CYCLES, 5, cycles from start to HI/LO commit for mult/multu (1..15)
DIV_CYCLES, 10, cycles from start to HI/LO commit for div/divu (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
e_hlu_control  in  4  E-stage op: 0001 mult family, 0010 div family, 0000 none
e_hlu_unsigned  in  1  1 = multu/divu
e_hlu_write  in  1  E-stage mthi/mtlo
e_hlu_dst  in  1  1 = HI, 0 = LO; applies to mthi/mtlo writes and mfhi/mflo reads
e_valid  in  1  E-stage instruction is real (not bubble)
e_cancel  in  1  E-stage instruction squashed this cycle (exception/eret flush)
e_a  in  32  rs operand
e_b  in  32  rt operand
d_hl_use  in  1  D-stage instr is cal_hl | read_hl | write_hl
busy  out  1  operation in flight
stall  out  1  freeze D, bubble E
hi  out  32  HI register
lo  out  32  LO register
rdata  out  32  e_hlu_dst ? hi : lo (combinational, mfhi/mflo)

Behaviour:
- Reset (async, reset_n low): hi=0, lo=0, busy=0, counter=0, state IDLE. stall=0 because it is driven from busy/start.
- Start condition:
  - start = e_valid & ~e_cancel & (e_hlu_control==0001 | e_hlu_control==0010) & ~busy.
  - On the start edge: latch the computed 64-bit result into the pending registers ph/pl, load counter = latency-1, busy<=1.
- States:
  - IDLE: on start go to RUN. If latency==1, commit on the next edge and return to IDLE.
  - RUN: counter decrements each cycle. At counter==0: hi<=ph, lo<=pl, busy<=0, go to IDLE.
  - With MULT_CYCLES=5, busy is high for exactly 5 cycles after the start edge. HI/LO are updated on the same edge that busy falls.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product; {hi,lo}=product.
  - multu: unsigned 32x32 to 64-bit product; {hi,lo}=product.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: lo=quotient, hi=remainder, unsigned.
  - Signed overflow 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero: sequence runs full latency, hi/lo unchanged.
- mthi/mtlo:
  - When e_valid & e_hlu_write & ~e_cancel & ~busy, hi or lo <= e_a on the next edge (per e_hlu_dst).
  - If busy, the write is ignored (protocol violation; the stall prevents it). Flag it with a simulation assertion.
- Cancel:
  - e_cancel blocks start and mthi/mtlo that cycle.
  - An op already in RUN is never cancelled and always commits.
- stall = d_hl_use & (busy | start). This holds an HI/LO-dependent D instruction until commit.
- rdata reads architectural hi/lo only. Pending results are never forwarded.
- Simultaneous events:
  - A start while busy cannot occur because stall keeps the next md op in D.
  - If seen anyway, it is ignored and asserted.
- Reset mid-RUN: pending result is discarded, all state returns to reset values.

Optional Feature:
- Macro HILO_MADD_EN.
- Defined:
  - e_hlu_control 0011 = madd/maddu and 0100 = msub/msubu (signedness from e_hlu_unsigned), latency MULT_CYCLES.
  - At commit: {hi,lo} <= {hi,lo} ± product, using hi/lo values at commit time, mod 2^64.
  - Both codes count as start ops.
- Undefined: codes 0011/0100 are no-ops. They do not start, do not set busy, and do not stall.

Decomposition:
- Package hilo_pkg:
  - op-code constants HLU_NONE=0000, HLU_MULT=0001, HLU_DIV=0010, HLU_MADD=0011, HLU_MSUB=0100
  - state enum IDLE/RUN
  - 4-bit counter width constant
- One sub-module, hilo_calc: purely combinational 64-bit result generator (mult/div/signed/unsigned/overflow/div-by-zero rules). hilo_seq keeps state, counter, commit and stall.

Test Plan:
1. mult with a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
2. div with a=-7, b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with a=7, b=0 -> 10 busy cycles, hi/lo unchanged.
3. mult started, mflo in D -> stall high on start cycle and all 5 busy cycles. Then rdata=new lo with e_hlu_dst=0. Stall=0 when d_hl_use=0.
4. div issued with e_cancel=1 -> busy stays 0, hi/lo unchanged. mtlo 0x1234 with e_cancel=1 -> lo unchanged. Without cancel -> lo=0x00001234 next edge.
5. reset_n dropped at cycle 3 of a mult -> busy=0, hi=lo=0 immediately (async). No commit after reset release.
6. With HILO_MADD_EN: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> hi=1, lo=0 after 5 cycles. Without macro: code 0011 -> busy stays 0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared op codes, state and commit-mode types for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam logic [3:0] HLU_NONE = 4'b0000;
    localparam logic [3:0] HLU_MULT = 4'b0001;
    localparam logic [3:0] HLU_DIV  = 4'b0010;
    localparam logic [3:0] HLU_MADD = 4'b0011;
    localparam logic [3:0] HLU_MSUB = 4'b0100;

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // How the pending {ph,pl} value is folded into HI/LO when the sequence ends
    typedef enum logic [1:0] {
        CM_KEEP,
        CM_LOAD,
        CM_ADD,
        CM_SUB
    } cmode_t;

endpackage

// File: rtl/hilo_calc.sv
// Combinational 64-bit mult/div result generator for hilo_seq.
// Optional madd/msub codes are enabled by defining HILO_MADD_EN.
module hilo_calc
    import hilo_pkg::*;
(
    input  logic [3:0]  op,
    input  logic        is_unsigned,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output cmode_t      mode
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        prod;
    logic               div_zero;
    logic               overflow;
    logic [31:0]        div_b;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'b0, a} * {32'b0, b};
    assign prod   = is_unsigned ? prod_u : prod_s;

    // Dividing the overflow case by 1 yields exactly quotient 0x80000000, remainder 0
    assign div_zero = (b == 32'd0);
    assign overflow = ~is_unsigned & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    assign div_b    = (div_zero | overflow) ? 32'd1 : b;

    assign quot_s = $signed(a) / $signed(div_b);
    assign rem_s  = $signed(a) % $signed(div_b);
    assign quot_u = a / div_b;
    assign rem_u  = a % div_b;

    always_comb begin
        result = '0;
        mode   = CM_KEEP;
        case (op)
            HLU_MULT: begin
                result = prod;
                mode   = CM_LOAD;
            end
            HLU_DIV: begin
                result = is_unsigned ? {rem_u, quot_u} : {rem_s, quot_s};
                mode   = div_zero ? CM_KEEP : CM_LOAD;
            end
`ifdef HILO_MADD_EN
            HLU_MADD: begin
                result = prod;
                mode   = CM_ADD;
            end
            HLU_MSUB: begin
                result = prod;
                mode   = CM_SUB;
            end
`endif
            default: begin
                result = '0;
                mode   = CM_KEEP;
            end
        endcase
    end

endmodule

// File: rtl/hilo_seq.sv
// HI/LO register pair with fixed-latency mult/div sequencing, mthi/mtlo writes and D-stage stall.
// Define HILO_MADD_EN to accept madd/msub (codes 0011/0100) as multiply-latency ops.
module hilo_seq
    import hilo_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  e_hlu_control,
    input  logic        e_hlu_unsigned,
    input  logic        e_hlu_write,
    input  logic        e_hlu_dst,
    input  logic        e_valid,
    input  logic        e_cancel,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_hl_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ph;
    logic [31:0]      pl;
    cmode_t           pmode;
    logic [63:0]      calc_result;
    cmode_t           calc_mode;
    logic             is_mul_op;
    logic             is_md_op;
    logic             start;
    logic             commit;
    logic             hl_write;

`ifdef HILO_MADD_EN
    assign is_mul_op = (e_hlu_control == HLU_MULT) | (e_hlu_control == HLU_MADD) |
                       (e_hlu_control == HLU_MSUB);
`else
    assign is_mul_op = (e_hlu_control == HLU_MULT);
`endif
    assign is_md_op = is_mul_op | (e_hlu_control == HLU_DIV);

    assign busy     = (state == RUN);
    assign start    = e_valid & ~e_cancel & is_md_op & ~busy;
    assign hl_write = e_valid & e_hlu_write & ~e_cancel & ~busy;
    assign commit   = busy & (cnt == '0);
    assign stall    = d_hl_use & (busy | start);
    assign rdata    = e_hlu_dst ? hi : lo;

    hilo_calc u_calc (
        .op          (e_hlu_control),
        .is_unsigned (e_hlu_unsigned),
        .a           (e_a),
        .b           (e_b),
        .result      (calc_result),
        .mode        (calc_mode)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)  state_next = RUN;
            RUN:     if (commit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The result is computed from E operands at start; madd/msub fold into HI/LO only at commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi    <= '0;
            lo    <= '0;
            ph    <= '0;
            pl    <= '0;
            pmode <= CM_KEEP;
            cnt   <= '0;
        end else begin
            if (start) begin
                {ph, pl} <= calc_result;
                pmode    <= calc_mode;
                cnt      <= is_mul_op ? MULT_LOAD : DIV_LOAD;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (commit) begin
                case (pmode)
                    CM_LOAD: {hi, lo} <= {ph, pl};
                    CM_ADD:  {hi, lo} <= {hi, lo} + {ph, pl};
                    CM_SUB:  {hi, lo} <= {hi, lo} - {ph, pl};
                    default: ;
                endcase
            end else if (hl_write) begin
                if (e_hlu_dst) hi <= e_a;
                else           lo <= e_a;
            end
        end
    end

    // The D-stage stall should keep md ops and mthi/mtlo out of E while a sequence runs
    assert property (@(posedge clk) disable iff (!reset_n)
        !(busy && e_valid && !e_cancel && (e_hlu_write || is_md_op)));

endmodule

// File: tb/tb_hilo_seq.sv
// Directed self-checking bench for hilo_seq; madd/msub checks follow HILO_MADD_EN.
module tb_hilo_seq;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  e_hlu_control;
    logic        e_hlu_unsigned;
    logic        e_hlu_write;
    logic        e_hlu_dst;
    logic        e_valid;
    logic        e_cancel;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_hl_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int compared   = 0;
    int mismatched = 0;
    int n_busy;
    int n_stall;

    always #5 clk = ~clk;

    hilo_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .e_hlu_control  (e_hlu_control),
        .e_hlu_unsigned (e_hlu_unsigned),
        .e_hlu_write    (e_hlu_write),
        .e_hlu_dst      (e_hlu_dst),
        .e_valid        (e_valid),
        .e_cancel       (e_cancel),
        .e_a            (e_a),
        .e_b            (e_b),
        .d_hl_use       (d_hl_use),
        .busy           (busy),
        .stall          (stall),
        .hi             (hi),
        .lo             (lo),
        .rdata          (rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic cancel, input logic [3:0] ctrl,
                                 input logic uns, input logic write, input logic dst,
                                 input logic [31:0] a, input logic [31:0] b);
        e_valid        = valid;
        e_cancel       = cancel;
        e_hlu_control  = ctrl;
        e_hlu_unsigned = uns;
        e_hlu_write    = write;
        e_hlu_dst      = dst;
        e_a            = a;
        e_b            = b;
    endtask

    // Presents one E-stage op for a single edge, then returns the bus to idle
    task automatic issueOp(input logic [3:0] ctrl, input logic uns, input logic cancel,
                           input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        applyStimulus(1'b1, cancel, ctrl, uns, 1'b0, 1'b0, a, b);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, HLU_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic writeHl(input logic dst, input logic cancel, input logic [31:0] val);
        @(negedge clk);
        applyStimulus(1'b1, cancel, HLU_NONE, 1'b0, 1'b1, dst, val, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, HLU_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Counts busy cycles after the start edge (bounded) and how many of them stalled
    task automatic waitIdle(output int nb, output int ns);
        nb = 0;
        ns = 0;
        while (busy && nb < 40) begin
            if (stall) ns++;
            @(posedge clk);
            #1;
            nb++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        d_hl_use = 1'b0;
        applyStimulus(1'b0, 1'b0, HLU_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #12;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] mult / multu");
        issueOp(HLU_MULT, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3);
        waitIdle(n_busy, n_stall);
        checkOutput("mult_cycles", 32'(n_busy), 32'd5);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
        issueOp(HLU_MULT, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
        waitIdle(n_busy, n_stall);
        checkOutput("multu_hi", hi, 32'h0000_0002);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

        $display("[TB] div / divu");
        issueOp(HLU_DIV, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        waitIdle(n_busy, n_stall);
        checkOutput("div_cycles", 32'(n_busy), 32'd10);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        issueOp(HLU_DIV, 1'b1, 1'b0, 32'd7, 32'd0);
        waitIdle(n_busy, n_stall);
        checkOutput("divz_cycles", 32'(n_busy), 32'd10);
        checkOutput("divz_hi", hi, 32'hFFFF_FFFF);
        checkOutput("divz_lo", lo, 32'hFFFF_FFFD);
        issueOp(HLU_DIV, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(n_busy, n_stall);
        checkOutput("divovf_hi", hi, 32'h0000_0000);
        checkOutput("divovf_lo", lo, 32'h8000_0000);
        issueOp(HLU_DIV, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE);
        waitIdle(n_busy, n_stall);
        checkOutput("divneg_hi", hi, 32'h0000_0001);
        checkOutput("divneg_lo", lo, 32'hFFFF_FFFD);
        issueOp(HLU_DIV, 1'b1, 1'b0, 32'd7, 32'd2);
        waitIdle(n_busy, n_stall);
        checkOutput("divu_hi", hi, 32'h0000_0001);
        checkOutput("divu_lo", lo, 32'h0000_0003);

        $display("[TB] stall and rdata");
        @(negedge clk);
        d_hl_use = 1'b1;
        applyStimulus(1'b1, 1'b0, HLU_MULT, 1'b0, 1'b0, 1'b0, 32'h0001_2345, 32'h10);
        #1;
        checkOutput("stall_start", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, HLU_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("rdata_no_fwd", rdata, 32'h0000_0003);
        waitIdle(n_busy, n_stall);
        checkOutput("stall_busy_cycles", 32'(n_stall), 32'd5);
        checkOutput("stall_after_commit", {31'b0, stall}, 32'd0);
        checkOutput("rdata_lo", rdata, 32'h0012_3450);
        e_hlu_dst = 1'b1;
        #1;
        checkOutput("rdata_hi", rdata, 32'h0000_0000);
        @(negedge clk);
        d_hl_use = 1'b0;
        issueOp(HLU_MULT, 1'b0, 1'b0, 32'd2, 32'd3);
        waitIdle(n_busy, n_stall);
        checkOutput("nouse_stall_cycles", 32'(n_stall), 32'd0);
        checkOutput("nouse_lo", lo, 32'd6);

        $display("[TB] cancel and mthi/mtlo");
        @(negedge clk);
        d_hl_use = 1'b1;
        applyStimulus(1'b1, 1'b1, HLU_DIV, 1'b0, 1'b0, 1'b0, 32'd100, 32'd5);
        #1;
        checkOutput("cancel_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, HLU_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        d_hl_use = 1'b0;
        checkOutput("cancel_busy", {31'b0, busy}, 32'd0);
        checkOutput("cancel_lo", lo, 32'd6);
        checkOutput("cancel_hi", hi, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, HLU_MULT, 1'b0, 1'b0, 1'b0, 32'd4, 32'd4);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, HLU_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("bubble_busy", {31'b0, busy}, 32'd0);
        writeHl(1'b0, 1'b1, 32'h0000_1234);
        checkOutput("mtlo_cancel", lo, 32'd6);
        writeHl(1'b0, 1'b0, 32'h0000_1234);
        checkOutput("mtlo", lo, 32'h0000_1234);
        writeHl(1'b1, 1'b0, 32'h0000_ABCD);
        checkOutput("mthi", hi, 32'h0000_ABCD);

        $display("[TB] reset during run");
        issueOp(HLU_MULT, 1'b0, 1'b0, 32'd3, 32'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("mid_run_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_hi", hi, 32'd0);
        checkOutput("async_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("post_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("post_reset_lo", lo, 32'd0);

`ifdef HILO_MADD_EN
        $display("[TB] madd / msub");
        writeHl(1'b0, 1'b0, 32'hFFFF_FFFF);
        issueOp(HLU_MADD, 1'b0, 1'b0, 32'd1, 32'd1);
        waitIdle(n_busy, n_stall);
        checkOutput("madd_cycles", 32'(n_busy), 32'd5);
        checkOutput("madd_hi", hi, 32'd1);
        checkOutput("madd_lo", lo, 32'd0);
        issueOp(HLU_MSUB, 1'b1, 1'b0, 32'd1, 32'd1);
        waitIdle(n_busy, n_stall);
        checkOutput("msub_hi", hi, 32'd0);
        checkOutput("msub_lo", lo, 32'hFFFF_FFFF);
`else
        $display("[TB] madd code without feature");
        @(negedge clk);
        d_hl_use = 1'b1;
        applyStimulus(1'b1, 1'b0, HLU_MADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        #1;
        checkOutput("madd_off_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, HLU_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        d_hl_use = 1'b0;
        checkOutput("madd_off_busy", {31'b0, busy}, 32'd0);
        checkOutput("madd_off_lo", lo, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
